// File: rtl/alu.sv
// Registered ALU with one-cycle latency: AND, OR, ADD, SUB, SLT and NOR plus carry/zero/negative flags.
// Define ALU_OVERFLOW_EN to add the registered signed-overflow flag output Overflow.
module alu #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALU_Sel,
    output logic [WIDTH-1:0] ALU_Out,
    output logic             CarryOut,
    output logic             Zero,
`ifdef ALU_OVERFLOW_EN
    output logic             Negative,
    output logic             Overflow
`else
    output logic             Negative
`endif
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    logic signed [WIDTH-1:0] w_a_s;
    logic signed [WIDTH-1:0] w_b_s;
    logic        [WIDTH:0]   w_sum;
    logic        [WIDTH:0]   w_diff;
    logic                    w_slt;
    logic        [WIDTH-1:0] w_res;
    logic                    w_carry;

    assign w_a_s  = A;
    assign w_b_s  = B;
    assign w_sum  = {1'b0, A} + {1'b0, B};
    // Subtraction as A + ~B + 1 so the carry out reads directly as "no borrow".
    assign w_diff = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
    assign w_slt  = (w_a_s < w_b_s);

    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        case (ALU_Sel)
            OP_AND: w_res = A & B;
            OP_OR:  w_res = A | B;
            OP_ADD: begin
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
            end
            OP_SUB: begin
                w_res   = w_diff[WIDTH-1:0];
                w_carry = w_diff[WIDTH];
            end
            OP_SLT: w_res = {{(WIDTH-1){1'b0}}, w_slt};
            OP_NOR: w_res = ~(A | B);
            default: begin
                w_res   = '0;
                w_carry = 1'b0;
            end
        endcase
    end

`ifdef ALU_OVERFLOW_EN
    logic w_ovf;

    always_comb begin
        w_ovf = 1'b0;
        if (ALU_Sel == OP_ADD)
            w_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
        else if (ALU_Sel == OP_SUB)
            w_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) Overflow <= 1'b0;
        else     Overflow <= w_ovf;
    end
`endif

    // Output register stage: flags come from the same result being registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ALU_Out  <= '0;
            CarryOut <= 1'b0;
            Zero     <= 1'b1;
            Negative <= 1'b0;
        end else begin
            ALU_Out  <= w_res;
            CarryOut <= w_carry;
            Zero     <= (w_res == '0);
            Negative <= w_res[WIDTH-1];
        end
    end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: stimulus pushes model predictions, a monitor pops and compares after each edge.
module tb_alu;

    localparam int W = 4;
    localparam int M = 1 << W;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [3:0]   ALU_Sel = '0;
    logic [W-1:0] ALU_Out;
    logic         CarryOut;
    logic         Zero;
    logic         Negative;
`ifdef ALU_OVERFLOW_EN
    logic         Overflow;
`endif

    alu #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .A(A),
        .B(B),
        .ALU_Sel(ALU_Sel),
        .ALU_Out(ALU_Out),
        .CarryOut(CarryOut),
        .Zero(Zero),
`ifdef ALU_OVERFLOW_EN
        .Negative(Negative),
        .Overflow(Overflow)
`else
        .Negative(Negative)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int out;
        bit c;
        bit z;
        bit n;
        bit v;
        int tag;
    } exp_t;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n_tag  = 0;

    task automatic check(input string name, input int tag, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s #%0d: got %0d, expected %0d", name, tag, act, exp);
        end
    endtask

    function automatic int to_signed(input int x);
        return (x >= M / 2) ? x - M : x;
    endfunction

    // Reference model from plain integer arithmetic.
    function automatic exp_t model(input int a, input int b, input int sel);
        exp_t e;
        int   s;
        int   ss;
        e.out = 0; e.c = 0; e.v = 0; e.tag = 0;
        case (sel)
            0:  e.out = a & b;
            1:  e.out = a | b;
            2: begin
                s     = a + b;
                e.out = s % M;
                e.c   = (s >= M);
                ss    = to_signed(a) + to_signed(b);
                e.v   = (ss > M / 2 - 1) || (ss < -(M / 2));
            end
            6: begin
                s     = a - b;
                e.out = (s + M) % M;
                e.c   = (a >= b);
                ss    = to_signed(a) - to_signed(b);
                e.v   = (ss > M / 2 - 1) || (ss < -(M / 2));
            end
            7:  e.out = (to_signed(a) < to_signed(b)) ? 1 : 0;
            12: e.out = (~(a | b)) & (M - 1);
            default: e.out = 0;
        endcase
        e.z = (e.out == 0);
        e.n = (e.out >= M / 2);
        return e;
    endfunction

    // Drives inputs now (caller is at a falling edge) and queues the expected result.
    task automatic drive(input int a, input int b, input int sel);
        exp_t e;
        A       = W'(a);
        B       = W'(b);
        ALU_Sel = 4'(sel);
        e       = model(a, b, sel);
        e.tag   = n_tag++;
        q.push_back(e);
    endtask

    task automatic apply(input int a, input int b, input int sel);
        @(negedge clk);
        drive(a, b, sel);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() != 0) begin
            e = q.pop_front();
            check("ALU_Out",  e.tag, int'(ALU_Out),  e.out);
            check("CarryOut", e.tag, int'(CarryOut), int'(e.c));
            check("Zero",     e.tag, int'(Zero),     int'(e.z));
            check("Negative", e.tag, int'(Negative), int'(e.n));
`ifdef ALU_OVERFLOW_EN
            check("Overflow", e.tag, int'(Overflow), int'(e.v));
`endif
        end
    end

    task automatic check_reset_values(input string name);
        check({name, "_out"}, 0, int'(ALU_Out),  0);
        check({name, "_c"},   0, int'(CarryOut), 0);
        check({name, "_z"},   0, int'(Zero),     1);
        check({name, "_n"},   0, int'(Negative), 0);
`ifdef ALU_OVERFLOW_EN
        check({name, "_v"},   0, int'(Overflow), 0);
`endif
    endtask

    initial begin
        int ops[7] = '{0, 1, 2, 6, 7, 12, 15};
        int wait_cnt;

        #1 rst = 1'b1;
        #1 check_reset_values("reset_init");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(5, 3, 0);
        apply(5, 3, 1);
        apply(5, 3, 2);
        apply(5, 3, 6);
        apply(5, 3, 7);
        apply(8, 3, 7);
        apply(5, 3, 12);
        apply(5, 3, 15);
        apply(15, 1, 2);
        apply(9, 9, 6);
        apply(3, 5, 6);
        apply(7, 1, 2);
        apply(8, 1, 6);

        for (int i = 0; i < 300; i++) begin
            int sel;
            if ($urandom_range(3) == 0) sel = int'($urandom_range(15));
            else                        sel = ops[$urandom_range(6)];
            apply(int'($urandom_range(M - 1)), int'($urandom_range(M - 1)), sel);
        end

        // Wrap-around, then an asynchronous reset between edges.
        apply(15, 1, 2);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1 check_reset_values("reset_async");
        check("queue_drained_before_reset", 0, q.size(), 0);

        // Inputs held during reset must not leak out; first result follows release.
        A = 4'd5; B = 4'd3; ALU_Sel = 4'd2;
        @(posedge clk);
        #1 check_reset_values("reset_held");
        @(negedge clk);
        rst = 1'b0;
        drive(6, 7, 6);
        apply(2, 2, 6);

        wait_cnt = 0;
        while (q.size() != 0 && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        @(negedge clk);
        check("queue_drained_final", 0, q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 Parameter WIDTH, default 4: operand and result width in bits, minimum 2.
REQ-002 clk  input  1: single clock; all state updates on its rising edge.
REQ-003 rst  input  1: asynchronous, active-high reset.
REQ-004 A  input  WIDTH: operand A.
REQ-005 B  input  WIDTH: operand B.
REQ-006 ALU_Sel  input  4: operation select.
REQ-007 ALU_Out  output  WIDTH: registered result.
REQ-008 CarryOut  output  1: registered carry / no-borrow flag.
REQ-009 Zero  output  1: registered flag, 1 when ALU_Out is all zeros.
REQ-010 Negative  output  1: registered flag, equal to ALU_Out[WIDTH-1].
REQ-011 Overflow  output  1: registered signed-overflow flag; port exists only when ALU_OVERFLOW_EN is defined.

Function
REQ-012 Opcode decode SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR.
REQ-013 AND/OR/NOR SHALL be bitwise A&B, A|B, ~(A|B); CarryOut=0.
REQ-014 ADD SHALL compute A+B modulo 2^WIDTH; CarryOut = bit WIDTH of the (WIDTH+1)-bit sum.
REQ-015 SUB SHALL compute A+~B+1 modulo 2^WIDTH; CarryOut = carry out of that sum (1 = no borrow, A>=B unsigned).
REQ-016 SLT SHALL output 1 (zero-extended to WIDTH) when A<B as two's-complement signed values, else 0; CarryOut=0.
REQ-017 Any other ALU_Sel value SHALL produce ALU_Out=0, CarryOut=0, hence Zero=1, Negative=0.
REQ-018 Zero and Negative SHALL be derived from the result being registered, in the same cycle as ALU_Out.
REQ-019 Latency SHALL be exactly one clock: inputs sampled at rising edge N appear on all outputs after edge N.
REQ-020 Outputs SHALL update every clock edge; no enable or handshake; changing ALU_Sel every cycle is legal.
REQ-021 Outputs SHALL hold their values between clock edges regardless of input changes.
REQ-022 Wrap-around: ADD 1111+0001 (WIDTH=4) SHALL give ALU_Out=0000, CarryOut=1, Zero=1.
REQ-023 SUB with A==B SHALL give ALU_Out=0, CarryOut=1, Zero=1.

Reset
REQ-024 While rst=1, outputs SHALL immediately (no clock needed) be ALU_Out=0, CarryOut=0, Zero=1, Negative=0, Overflow=0 (if present).
REQ-025 Reset asserted mid-operation SHALL discard the in-flight result; first result after release is from inputs at the first rising edge with rst=0.

Configuration
REQ-026 Macro ALU_OVERFLOW_EN defined: Overflow port present; for ADD, 1 when A and B share sign and result sign differs; for SUB, 1 when A and B differ in sign and result sign differs from A; 0 for all other opcodes.
REQ-027 Macro ALU_OVERFLOW_EN undefined: no Overflow port and no overflow logic; all other behaviour identical.

Verification (WIDTH=4, A=0101, B=0011 unless stated; values checked one edge after applying)
REQ-028 AND -> ALU_Out=0001, Zero=0, Neg=0; OR -> 0111, Zero=0, Neg=0.
REQ-029 ADD -> ALU_Out=1000, CarryOut=0, Neg=1, Overflow=1 (when enabled); SUB -> 0010, CarryOut=1, Neg=0, Overflow=0.
REQ-030 SLT -> 0000, Zero=1; SLT with A=1000, B=0011 -> 0001 (signed compare).
REQ-031 NOR -> ALU_Out=1000, Zero=0, Neg=1; ALU_Sel=1111 -> 0000, Zero=1, CarryOut=0.
REQ-032 ADD 1111+0001 -> 0000, CarryOut=1, Zero=1; then assert rst between edges -> outputs go to reset values at once, before the next edge.
